// File: rtl/md5_search_ctrl.sv
// md5_search_ctrl: feeds candidate messages into an md5core pipeline, tracks
// outstanding work, compares returned digests against a target and reports
// the first matching message. Run control: IDLE -> RUN -> DRAIN -> DONE.
module md5_search_ctrl #(
   parameter int MAX_INFLIGHT  = 255,
   parameter int STOP_ON_MATCH = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         stop,
   input  logic [127:0] target_hash,
   input  logic [151:0] msg_in,
   input  logic         msg_valid,
   output logic         msg_ready,
   output logic         core_en,
   output logic [151:0] core_m_in,
   output logic         core_valid_in,
   input  logic [31:0]  core_a,
   input  logic [31:0]  core_b,
   input  logic [31:0]  core_c,
   input  logic [31:0]  core_d,
   input  logic [151:0] core_m_out,
   input  logic         core_valid_out,
   output logic         busy,
   output logic         done,
   output logic         match,
   output logic         err,
   output logic [151:0] match_mesg,
   output logic [31:0]  issue_count,
   output logic [31:0]  hit_count,
   output logic [7:0]   inflight
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [7:0] MAX_I = 8'(MAX_INFLIGHT);

   state_t         state;
   logic [127:0]   target;
   logic           cmp_vld;
   logic           cmp_hit;
   logic [151:0]   cmp_mesg;

   logic active, start_acc, xfer, retire, spurious, hit;

   assign active    = (state == RUN) || (state == DRAIN);
   assign start_acc = start && ((state == IDLE) || (state == DONE));
   assign msg_ready = (state == RUN) && !stop && (inflight < MAX_I);
   assign xfer      = msg_valid && msg_ready;
   // Results are only meaningful while a run is active; anything arriving in
   // IDLE/DONE (e.g. leftovers from a reset-abandoned run) is dropped.
   assign retire    = active && core_valid_out && (inflight != 8'd0);
   assign spurious  = active && core_valid_out && (inflight == 8'd0);
   assign hit       = cmp_vld && cmp_hit;

   // Run-control FSM; busy/done/core_en are registered alongside the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         core_en <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state   <= RUN;
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  core_en <= 1'b1;
               end
            end
            RUN: begin
               if (stop || ((STOP_ON_MATCH != 0) && hit && !match))
                  state <= DRAIN;
            end
            DRAIN: begin
               // Wait for every issued message to retire and be compared.
               if ((inflight == 8'd0) && !cmp_vld) begin
                  state   <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  core_en <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Issue register toward md5core; data is zeroed when nothing transfers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         core_valid_in <= 1'b0;
         core_m_in     <= '0;
      end else begin
         core_valid_in <= xfer;
         core_m_in     <= xfer ? msg_in : '0;
      end
   end

   // Bookkeeping: counters, outstanding count, compare stage and match capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         target      <= '0;
         issue_count <= '0;
         hit_count   <= '0;
         inflight    <= '0;
         err         <= 1'b0;
         match       <= 1'b0;
         match_mesg  <= '0;
         cmp_vld     <= 1'b0;
         cmp_hit     <= 1'b0;
         cmp_mesg    <= '0;
      end else if (start_acc) begin
         target      <= target_hash;
         issue_count <= '0;
         hit_count   <= '0;
         inflight    <= '0;
         err         <= 1'b0;
         match       <= 1'b0;
         match_mesg  <= '0;
         cmp_vld     <= 1'b0;
      end else begin
         if (xfer)
            issue_count <= issue_count + 32'd1;
         case ({xfer, retire})
            2'b10:   inflight <= inflight + 8'd1;
            2'b01:   inflight <= inflight - 8'd1;
            default: inflight <= inflight;
         endcase
         if (spurious)
            err <= 1'b1;
         // Compare is registered: the digest is checked here and the hit is
         // counted one edge later, which is what "compare pending" refers to.
         cmp_vld  <= retire;
         cmp_hit  <= ({core_a, core_b, core_c, core_d} == target);
         cmp_mesg <= core_m_out;
         if (hit) begin
            hit_count <= hit_count + 32'd1;
            if (!match) begin
               match      <= 1'b1;
               match_mesg <= cmp_mesg;
            end
         end
      end
   end

endmodule

// File: tb/tb_md5_search_ctrl.sv
// Bench for md5_search_ctrl: a stand-in md5core with random in-order latency,
// a cycle-level reference model of the controller rules, directed scenarios
// and randomized search runs.
module tb_md5_search_ctrl;

   localparam int MAXI    = 2;
   localparam int STOP_ON = 1;

   localparam logic [151:0] FOX   = "The quick brown fox";
   localparam logic [151:0] HELLO = "Hello World 1234567";
   localparam logic [151:0] TEST  = "This is a test. 123";
   localparam logic [127:0] T_FOX   = 128'ha2004f37730b9445670a738fa0fc9ee5;
   localparam logic [127:0] T_HELLO = 128'hac98cf84ae657376cea165e6729ddb39;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0, stop = 1'b0;
   logic [127:0] target_hash = '0;
   logic [151:0] msg_in = '0;
   logic         msg_valid = 1'b0;
   logic         msg_ready;
   logic         core_en;
   logic [151:0] core_m_in;
   logic         core_valid_in;
   logic [31:0]  core_a = '0, core_b = '0, core_c = '0, core_d = '0;
   logic [151:0] core_m_out = '0;
   logic         core_valid_out = 1'b0;
   logic         busy, done, match, err;
   logic [151:0] match_mesg;
   logic [31:0]  issue_count, hit_count;
   logic [7:0]   inflight;

   md5_search_ctrl #(.MAX_INFLIGHT(MAXI), .STOP_ON_MATCH(STOP_ON)) dut (
      .clk(clk), .reset(rst), .start(start), .stop(stop),
      .target_hash(target_hash),
      .msg_in(msg_in), .msg_valid(msg_valid), .msg_ready(msg_ready),
      .core_en(core_en), .core_m_in(core_m_in), .core_valid_in(core_valid_in),
      .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d),
      .core_m_out(core_m_out), .core_valid_out(core_valid_out),
      .busy(busy), .done(done), .match(match), .err(err),
      .match_mesg(match_mesg), .issue_count(issue_count),
      .hit_count(hit_count), .inflight(inflight)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [151:0] obs, input logic [151:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Stand-in digest: the two reference strings map to their real MD5 values,
   // everything else gets a cheap deterministic scramble.
   function automatic logic [127:0] dig(input logic [151:0] m);
      if (m == FOX)   return T_FOX;
      if (m == HELLO) return T_HELLO;
      return {m[151:120] ^ m[31:0], m[119:88] ^ 32'h9e3779b9,
              m[87:56] + m[55:24], m[23:0], m[151:144]};
   endfunction

   function automatic logic [151:0] rnd152();
      logic [159:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return t[151:0];
   endfunction

   // ---------------- reference model (sampled just before each rising edge)
   int           m_state = 0;        // 0 idle, 1 run, 2 drain, 3 done
   int           m_infl = 0, max_infl = 0;
   logic [31:0]  m_issue = '0, m_hits = '0;
   logic         m_match = 1'b0, m_err = 1'b0;
   logic [151:0] m_mesg = '0, m_cmp_mesg = '0;
   logic [127:0] m_target = '0;
   logic         m_cmp_vld = 1'b0, m_cmp_hit = 1'b0;
   logic [151:0] m_sent[$];

   always begin : model
      int  n_state;
      logic exp_rdy, xfer, ret, n_cmp;
      @(negedge clk); #4;
      if (rst) begin
         m_state = 0; m_infl = 0; m_cmp_vld = 1'b0; m_err = 1'b0;
         m_issue = '0; m_hits = '0; m_match = 1'b0; m_mesg = '0;
      end else begin
         exp_rdy = (m_state == 1) && !stop && (m_infl < MAXI);
         chk("busy",      busy,      (m_state == 1) || (m_state == 2));
         chk("core_en",   core_en,   (m_state == 1) || (m_state == 2));
         chk("done",      done,      m_state == 3);
         chk("msg_ready", msg_ready, exp_rdy);
         chk("inflight",  inflight,  m_infl);
         chk("err",       err,       m_err);
         chk("issue_cnt", issue_count, m_issue);
         chk("hit_cnt",   hit_count, m_hits);
         chk("match",     match,     m_match);
         if (int'(inflight) > max_infl) max_infl = int'(inflight);
         xfer = msg_valid && exp_rdy;
         if (xfer) m_sent.push_back(msg_in);
         ret = core_valid_out && ((m_state == 1) || (m_state == 2));
         n_state = m_state;
         if (m_cmp_vld && m_cmp_hit) begin
            m_hits = m_hits + 1;
            if (!m_match) begin
               m_match = 1'b1;
               m_mesg  = m_cmp_mesg;
               if (STOP_ON != 0 && m_state == 1) n_state = 2;
            end
         end
         if (m_state == 1 && stop) n_state = 2;
         if (m_state == 2 && m_infl == 0 && !m_cmp_vld) n_state = 3;
         if ((m_state == 0 || m_state == 3) && start) begin
            n_state  = 1;
            m_target = target_hash;
            m_issue = '0; m_hits = '0; m_match = 1'b0; m_mesg = '0;
            m_err = 1'b0; m_infl = 0; m_cmp_vld = 1'b0;
         end else begin
            if (ret && m_infl == 0) m_err = 1'b1;
            n_cmp      = ret && (m_infl != 0);
            m_infl     = m_infl + int'(xfer) - int'(n_cmp);
            m_issue    = m_issue + 32'(xfer);
            m_cmp_vld  = n_cmp;
            m_cmp_hit  = ({core_a, core_b, core_c, core_d} == m_target);
            m_cmp_mesg = core_m_out;
         end
         m_state = n_state;
      end
   end

   // ---------------- stand-in md5core: in-order, random latency
   typedef struct { logic [151:0] m; int due; } job_t;
   job_t q[$];
   int   cyc = 0;
   int   lat_min = 1, lat_max = 4;
   logic man_mode = 1'b0, man_fire = 1'b0;
   logic [151:0] man_msg = '0;

   always begin : core_model
      job_t j;
      logic [151:0] exp_m;
      @(negedge clk); #2;
      cyc++;
      if (core_valid_in) begin
         if (m_sent.size() == 0) chk("core_spurious", 1'b1, 1'b0);
         else begin
            exp_m = m_sent.pop_front();
            chk("core_m_in", core_m_in, exp_m);
         end
         if (!man_mode) begin
            j.m   = core_m_in;
            j.due = cyc + int'($urandom_range(lat_min, lat_max));
            if (q.size() > 0 && j.due <= q[$].due) j.due = q[$].due + 1;
            q.push_back(j);
         end
      end
      if (man_fire) begin
         core_valid_out = 1'b1;
         core_m_out     = man_msg;
         {core_a, core_b, core_c, core_d} = dig(man_msg);
      end else if (q.size() > 0 && q[0].due <= cyc) begin
         j = q.pop_front();
         core_valid_out = 1'b1;
         core_m_out     = j.m;
         {core_a, core_b, core_c, core_d} = dig(j.m);
      end else begin
         // Idle bus carries a matching digest so an unqualified compare shows up.
         core_valid_out = 1'b0;
         core_m_out     = rnd152();
         {core_a, core_b, core_c, core_d} = target_hash;
      end
   end

   // ---------------- stimulus helpers
   task automatic step();
      @(negedge clk); #1;
   endtask

   task automatic start_run(input logic [127:0] t);
      target_hash = t;
      start = 1'b1; step(); start = 1'b0;
   endtask

   task automatic send(input logic [151:0] m);
      logic [31:0] n0;
      n0 = m_issue;
      msg_in = m; msg_valid = 1'b1;
      for (int k = 0; k < 100; k++) begin
         step();
         if (m_issue != n0) break;
      end
      if (m_issue == n0) chk("send_timeout", 1'b0, 1'b1);
   endtask

   task automatic wait_done(input string tag);
      for (int k = 0; k < 400; k++) begin
         if (done) break;
         step();
      end
      chk(tag, done, 1'b1);
   endtask

   task automatic pulse_stop();
      stop = 1'b1; step(); stop = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"},  busy, 1'b0);
      chk({tag, "_done"},  done, 1'b0);
      chk({tag, "_en"},    core_en, 1'b0);
      chk({tag, "_rdy"},   msg_ready, 1'b0);
      chk({tag, "_cvin"},  core_valid_in, 1'b0);
      chk({tag, "_cmin"},  core_m_in, '0);
      chk({tag, "_iss"},   issue_count, '0);
      chk({tag, "_hit"},   hit_count, '0);
      chk({tag, "_infl"},  inflight, '0);
      chk({tag, "_match"}, match, 1'b0);
      chk({tag, "_mesg"},  match_mesg, '0);
      chk({tag, "_err"},   err, 1'b0);
   endtask

   task automatic random_run(input int idx);
      logic [151:0] pool[4];
      int  k_max, sel;
      logic stop_sent;
      pool[0] = FOX; pool[1] = HELLO; pool[2] = TEST; pool[3] = rnd152();
      sel = int'($urandom_range(0, 4));
      lat_min = 1; lat_max = int'($urandom_range(1, 6));
      k_max = int'($urandom_range(3, 10));
      stop_sent = 1'b0;
      start_run(sel == 4 ? {$urandom, $urandom, $urandom, $urandom} : dig(pool[sel]));
      for (int c = 0; c < 400; c++) begin
         if (done) break;
         msg_valid = (m_issue < 32'(k_max)) && ($urandom_range(0, 3) != 0);
         msg_in    = pool[$urandom_range(0, 3)];
         stop      = (m_issue >= 32'(k_max)) && !stop_sent;
         if (stop) stop_sent = 1'b1;
         start     = (c == 3);           // must be ignored mid-run
         step();
      end
      msg_valid = 1'b0; stop = 1'b0; start = 1'b0;
      chk($sformatf("rnd%0d_done", idx), done, 1'b1);
      chk($sformatf("rnd%0d_iss", idx),  issue_count, m_issue);
      chk($sformatf("rnd%0d_hit", idx),  hit_count, m_hits);
      chk($sformatf("rnd%0d_mesg", idx), match_mesg, m_mesg);
      chk($sformatf("rnd%0d_infl", idx), inflight, '0);
   endtask

   // ---------------- main sequence
   initial begin
      repeat (3) step();
      chk_zero("rst");
      rst = 1'b0;
      step();

      // Auto-drain on first hit: FOX matches.
      lat_min = 3; lat_max = 3;
      start_run(T_FOX);
      send(FOX); send(HELLO); send(TEST);
      msg_valid = 1'b0;
      wait_done("A_done");
      chk("A_iss",   issue_count, 32'd3);
      chk("A_hit",   hit_count, 32'd1);
      chk("A_match", match, 1'b1);
      chk("A_mesg",  match_mesg, FOX);
      chk("A_infl",  inflight, 8'd0);

      // Second message matches; stop pulse after issuing.
      lat_min = 1; lat_max = 4;
      start_run(T_HELLO);
      send(FOX); send(HELLO); send(TEST);
      msg_valid = 1'b0;
      pulse_stop();
      wait_done("B_done");
      chk("B_iss",  issue_count, 32'd3);
      chk("B_hit",  hit_count, 32'd1);
      chk("B_mesg", match_mesg, HELLO);

      // Back-pressure at MAX_INFLIGHT with msg_valid held high.
      lat_min = 6; lat_max = 6; max_infl = 0;
      start_run('0);
      msg_valid = 1'b1;
      for (int c = 0; c < 30; c++) begin
         msg_in = rnd152();
         step();
      end
      msg_valid = 1'b0;
      pulse_stop();
      wait_done("C_done");
      chk("C_max_infl", max_infl, MAXI);
      chk("C_match", match, 1'b0);

      // Hand-driven retires: simultaneous transfer/retire, then spurious retire.
      man_mode = 1'b1;
      start_run('0);
      send(TEST);
      msg_in = FOX; man_msg = TEST; man_fire = 1'b1;
      step();
      chk("D_same_infl", inflight, 8'd1);
      chk("D_same_iss",  issue_count, 32'd2);
      msg_valid = 1'b0; man_msg = FOX;
      step();
      chk("D_ret_infl", inflight, 8'd0);
      chk("D_ret_err",  err, 1'b0);
      step();
      man_fire = 1'b0;
      step();
      chk("D_err",      err, 1'b1);
      chk("D_err_infl", inflight, 8'd0);
      pulse_stop();
      wait_done("D_done");
      man_mode = 1'b0;

      // Reset in the middle of a run with work outstanding.
      lat_min = 20; lat_max = 20;
      start_run(dig(TEST));
      send(FOX); send(HELLO); send(TEST);
      msg_valid = 1'b0;
      repeat (10) step();
      rst = 1'b1;
      #1;
      chk_zero("E_rst");
      step();
      rst = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (q.size() == 0) break;
         step();
      end
      repeat (3) step();
      chk("E_err_after", err, 1'b0);
      chk("E_infl_after", inflight, 8'd0);
      chk("E_busy_after", busy, 1'b0);
      lat_min = 1; lat_max = 3;
      start_run(dig(TEST));
      send(HELLO); send(TEST);
      msg_valid = 1'b0;
      wait_done("E2_done");
      chk("E2_err",  err, 1'b0);
      chk("E2_mesg", match_mesg, TEST);
      chk("E2_hit",  hit_count, 32'd1);

      for (int r = 0; r < 10; r++) random_run(r);

      repeat (2) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
